// File: rtl/ov7670_cfg_sequencer.sv
// Walks an (addr, data) register table and issues one SCCB write per entry,
// with power-up wait, delay/end markers, NACK retry and a busy timeout.
module ov7670_cfg_sequencer #(
   parameter int IDX_W        = 7,
   parameter int MAX_RETRIES  = 3,
   parameter int DELAY_UNIT   = 800,
   parameter int START_DELAY  = 800,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic             clk_800KHz,
   input  logic             rst_n,
   input  logic             start,
   output logic [IDX_W-1:0] rom_index,
   input  logic [7:0]       rom_addr,
   input  logic [7:0]       rom_data,
   output logic [7:0]       sccb_addr,
   output logic [7:0]       sccb_data,
   output logic             sccb_en,
   input  logic             sccb_ready,
   input  logic             sccb_busy,
   input  logic             sccb_ack,
   output logic             running,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_index
);

   localparam int               TO_W      = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = '1;
   localparam logic [31:0]      START_CNT = 32'(START_DELAY);
   localparam logic [31:0]      UNIT_CNT  = 32'(DELAY_UNIT);
   localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

   typedef enum logic [3:0] {
      IDLE, PWR_WAIT, FETCH, DECODE, ISSUE, WAIT_DONE, CHECK, DELAY, DONE, ERROR
   } state_t;

   state_t           state, state_n;
   logic [31:0]      cnt, cnt_n;
   logic [TO_W-1:0]  tcnt, tcnt_n;
   logic [7:0]       retry, retry_n;
   logic             ack_r, ack_n;
   logic [IDX_W-1:0] index_n, err_index_n;
   logic [7:0]       addr_n, data_n;
   logic             en_n, running_n, done_n, error_n;

   always_ff @(posedge clk_800KHz) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         tcnt      <= '0;
         retry     <= '0;
         ack_r     <= 1'b0;
         rom_index <= '0;
         sccb_addr <= '0;
         sccb_data <= '0;
         sccb_en   <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_index <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         tcnt      <= tcnt_n;
         retry     <= retry_n;
         ack_r     <= ack_n;
         rom_index <= index_n;
         sccb_addr <= addr_n;
         sccb_data <= data_n;
         sccb_en   <= en_n;
         running   <= running_n;
         done      <= done_n;
         error     <= error_n;
         err_index <= err_index_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      tcnt_n      = tcnt;
      retry_n     = retry;
      ack_n       = ack_r;
      index_n     = rom_index;
      addr_n      = sccb_addr;
      data_n      = sccb_data;
      en_n        = sccb_en;
      running_n   = running;
      done_n      = done;
      error_n     = error;
      err_index_n = err_index;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_n   = PWR_WAIT;
               cnt_n     = START_CNT;
               index_n   = '0;
               retry_n   = '0;
               done_n    = 1'b0;
               error_n   = 1'b0;
               running_n = 1'b1;
            end
         end
         // Counters stop at 1 so a load of n gives n wait cycles (and 0 gives one).
         PWR_WAIT: begin
            if (cnt <= 32'd1) state_n = FETCH;
            else              cnt_n   = cnt - 32'd1;
         end
         FETCH: state_n = DECODE;
         DECODE: begin
            if (rom_addr == 8'hFF && rom_data == 8'hFF) begin
               state_n   = DONE;
               done_n    = 1'b1;
               running_n = 1'b0;
            end else if (rom_addr == 8'hFE) begin
               state_n = DELAY;
               cnt_n   = {24'd0, rom_data} * UNIT_CNT;
            end else begin
               state_n = ISSUE;
               addr_n  = rom_addr;
               data_n  = rom_data;
               en_n    = sccb_ready;
               tcnt_n  = '0;
            end
         end
         ISSUE: begin
            if (sccb_en) begin
               if (sccb_busy) begin
                  en_n    = 1'b0;
                  state_n = WAIT_DONE;
               end else if (tcnt == TO_LAST) begin
                  en_n    = 1'b0;
                  ack_n   = 1'b0;
                  state_n = CHECK;
               end else begin
                  tcnt_n = tcnt + TO_W'(1);
               end
            end else if (sccb_ready) begin
               en_n   = 1'b1;
               tcnt_n = '0;
            end
         end
         WAIT_DONE: begin
            if (!sccb_busy) begin
               ack_n   = sccb_ack;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (ack_r) begin
               retry_n = '0;
               if (rom_index == LAST_IDX) begin
                  state_n   = DONE;
                  done_n    = 1'b1;
                  running_n = 1'b0;
               end else begin
                  index_n = rom_index + IDX_W'(1);
                  state_n = FETCH;
               end
            end else begin
               retry_n = retry + 8'd1;
               if ((retry + 8'd1) < RETRY_MAX) begin
                  state_n = ISSUE;
                  en_n    = sccb_ready;
                  tcnt_n  = '0;
               end else begin
                  err_index_n = rom_index;
                  error_n     = 1'b1;
                  running_n   = 1'b0;
                  state_n     = ERROR;
               end
            end
         end
         DELAY: begin
            if (cnt <= 32'd1) begin
               if (rom_index == LAST_IDX) begin
                  state_n   = DONE;
                  done_n    = 1'b1;
                  running_n = 1'b0;
               end else begin
                  index_n = rom_index + IDX_W'(1);
                  state_n = FETCH;
               end
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: directed table vectors, hand sequences and
// random tables against a behavioural SCCB slave and table-walk model.
module tb_ov7670_cfg_sequencer;

   localparam int IDX_W  = 3;
   localparam int N      = 8;
   localparam int MAXR   = 3;
   localparam int DU     = 10;
   localparam int SD     = 8;
   localparam int BT     = 64;
   localparam int BUDGET = 20000;

   logic             clk = 1'b0;
   logic             rst_n, start;
   logic [IDX_W-1:0] rom_index, err_index;
   logic [7:0]       rom_addr, rom_data, sccb_addr, sccb_data;
   logic             sccb_en, sccb_ready, sccb_busy, sccb_ack;
   logic             running, done, error;

   always #5 clk = ~clk;

   ov7670_cfg_sequencer #(
      .IDX_W(IDX_W), .MAX_RETRIES(MAXR), .DELAY_UNIT(DU),
      .START_DELAY(SD), .BUSY_TIMEOUT(BT)
   ) dut (
      .clk_800KHz(clk), .rst_n(rst_n), .start(start), .rom_index(rom_index),
      .rom_addr(rom_addr), .rom_data(rom_data), .sccb_addr(sccb_addr),
      .sccb_data(sccb_data), .sccb_en(sccb_en), .sccb_ready(sccb_ready),
      .sccb_busy(sccb_busy), .sccb_ack(sccb_ack), .running(running),
      .done(done), .error(error), .err_index(err_index)
   );

   // Register table and slave behaviour knobs (written by the main process only).
   logic [7:0] rom_a [N];
   logic [7:0] rom_d [N];
   int         cfg_nack [N];
   bit         cfg_mute [N];
   int         fix_len = 2;
   bit         rnd_len = 0;
   bit         rnd_ready = 0;

   assign rom_addr = rom_a[rom_index];
   assign rom_data = rom_d[rom_index];

   // SCCB slave model: accepts en when idle, stays busy a few cycles, then
   // presents ack; NACKs the first cfg_nack attempts of each entry.
   logic       busy_r = 1'b0, ack_r = 1'b0, ack_pend = 1'b0, rdy_gate = 1'b1;
   int         bcnt = 0, log_n = 0, hold_err = 0;
   int         att [N];
   logic [7:0] cur_a = 8'd0, cur_d = 8'd0;
   logic [7:0] log_a [1024];
   logic [7:0] log_d [1024];
   int         log_i [1024];

   assign sccb_busy  = busy_r;
   assign sccb_ack   = ack_r;
   assign sccb_ready = !busy_r && rdy_gate;

   always @(posedge clk) rdy_gate <= rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;

   always @(posedge clk) begin
      if (start && !running)
         for (int k = 0; k < N; k++) att[k] <= 0;
      if (!rst_n) begin
         busy_r <= 1'b0;
         ack_r  <= 1'b0;
      end else if (busy_r) begin
         if (bcnt == 0) begin
            busy_r <= 1'b0;
            ack_r  <= ack_pend;
            if (sccb_addr !== cur_a || sccb_data !== cur_d) hold_err <= hold_err + 1;
         end else begin
            bcnt <= bcnt - 1;
         end
      end else if (sccb_en && !cfg_mute[rom_index]) begin
         busy_r   <= 1'b1;
         ack_r    <= 1'b0;
         bcnt     <= rnd_len ? int'($urandom_range(0, 5)) : fix_len;
         ack_pend <= (att[rom_index] >= cfg_nack[rom_index]);
         att[rom_index]   <= att[rom_index] + 1;
         cur_a            <= sccb_addr;
         cur_d            <= sccb_data;
         log_a[log_n % 1024] <= sccb_addr;
         log_d[log_n % 1024] <= sccb_data;
         log_i[log_n % 1024] <= int'(rom_index);
         log_n            <= log_n + 1;
      end
   end

   typedef struct packed {
      logic [N-1:0][15:0] tbl;
      logic [N-1:0][1:0]  nack;
      logic [N-1:0]       mute;
      logic               done;
      logic               err;
      logic [2:0]         eidx;
      logic [2:0]         idx;
      logic [7:0]         writes;
   } vec_t;

   vec_t vecs [8];

   int checks = 0, errors = 0;
   int first_en, dwell1, maxrun;

   // Expected pass outcome from the table-walk model.
   logic [7:0] m_a [64];
   logic [7:0] m_d [64];
   int         m_i [64];
   int         m_n, m_idx, m_eidx;
   bit         m_done, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t blank();
      vec_t v;
      v = '0;
      for (int k = 0; k < N; k++) v.tbl[k] = 16'hFFFF;
      return v;
   endfunction

   task automatic load_vec(input vec_t v);
      for (int k = 0; k < N; k++) begin
         rom_a[k]    = v.tbl[k][15:8];
         rom_d[k]    = v.tbl[k][7:0];
         cfg_nack[k] = int'(v.nack[k]);
         cfg_mute[k] = v.mute[k];
      end
   endtask

   task automatic model();
      int  i;
      bit  ok;
      m_n = 0; m_done = 0; m_err = 0; m_eidx = 0; m_idx = 0;
      i = 0;
      for (int step = 0; step <= N; step++) begin
         if (rom_a[i] == 8'hFF && rom_d[i] == 8'hFF) begin
            m_done = 1; m_idx = i; break;
         end
         if (rom_a[i] == 8'hFE) begin
            if (i == N - 1) begin m_done = 1; m_idx = i; break; end
            i++;
            continue;
         end
         ok = 0;
         for (int a = 0; a < MAXR && !ok; a++) begin
            if (!cfg_mute[i]) begin
               m_a[m_n] = rom_a[i]; m_d[m_n] = rom_d[i]; m_i[m_n] = i; m_n++;
            end
            ok = !cfg_mute[i] && a >= cfg_nack[i];
         end
         if (!ok) begin m_err = 1; m_eidx = i; m_idx = i; break; end
         if (i == N - 1) begin m_done = 1; m_idx = i; break; end
         i++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rom_index"}, rom_index, 0);
      chk({tag, "_sccb_addr"}, sccb_addr, 0);
      chk({tag, "_sccb_data"}, sccb_data, 0);
      chk({tag, "_sccb_en"},   sccb_en, 0);
      chk({tag, "_running"},   running, 0);
      chk({tag, "_done"},      done, 0);
      chk({tag, "_error"},     error, 0);
      chk({tag, "_err_index"}, err_index, 0);
   endtask

   task automatic run_pass(input bit mid_start);
      int base, hbase, cyc, run, got;
      bit sent, en_seen;
      model();
      base = log_n; hbase = hold_err;
      first_en = -1; dwell1 = 0; maxrun = 0; run = 0; sent = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_clears_done", done, 0);
      chk("start_clears_error", error, 0);
      chk("start_sets_running", running, 1);
      cyc = 0;
      while (!(done || error) && cyc < BUDGET) begin
         if (sccb_en && first_en < 0) first_en = cyc;
         if (rom_index == 3'd1) dwell1++;
         run = sccb_en ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         start = 1'b0;
         if (mid_start && !sent && rom_index == 3'd1) begin start = 1'b1; sent = 1; end
         tick();
         cyc++;
      end
      start = 1'b0;
      chk("pass_finished", done | error, 1);
      en_seen = 0;
      repeat (5) begin
         if (sccb_en) en_seen = 1;
         tick();
      end
      chk("no_en_after_end", en_seen, 0);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("running_end", running, 0);
      chk("rom_index_end", rom_index, m_idx);
      if (m_err) chk("err_index", err_index, m_eidx);
      got = log_n - base;
      chk("write_count", got, m_n);
      for (int j = 0; j < m_n && j < got; j++) begin
         chk($sformatf("w%0d_addr", j), log_a[(base + j) % 1024], m_a[j]);
         chk($sformatf("w%0d_data", j), log_d[(base + j) % 1024], m_d[j]);
         chk($sformatf("w%0d_index", j), log_i[(base + j) % 1024], m_i[j]);
      end
      chk("addr_data_held", hold_err - hbase, 0);
   endtask

   task automatic check_rec(input int v);
      chk($sformatf("v%0d_done", v), done, vecs[v].done);
      chk($sformatf("v%0d_error", v), error, vecs[v].err);
      chk($sformatf("v%0d_index", v), rom_index, vecs[v].idx);
      if (vecs[v].err) chk($sformatf("v%0d_err_index", v), err_index, vecs[v].eidx);
   endtask

   initial begin
      int cyc, r;
      vecs[0] = blank(); vecs[0].tbl[0] = 16'h1280;
      vecs[0].done = 1; vecs[0].idx = 1; vecs[0].writes = 1;
      vecs[1] = blank(); vecs[1].tbl[0] = 16'h4FB3; vecs[1].tbl[1] = 16'h50B3;
      vecs[1].done = 1; vecs[1].idx = 2; vecs[1].writes = 2;
      vecs[2] = blank(); vecs[2].tbl[0] = 16'h1234; vecs[2].nack[0] = 2'd2;
      vecs[2].done = 1; vecs[2].idx = 1; vecs[2].writes = 3;
      vecs[3] = vecs[1]; vecs[3].nack[1] = 2'd3;
      vecs[3].done = 0; vecs[3].err = 1; vecs[3].eidx = 1; vecs[3].idx = 1; vecs[3].writes = 4;
      vecs[4] = blank(); vecs[4].tbl[0] = 16'h1280; vecs[4].tbl[1] = 16'hFE02;
      vecs[4].tbl[2] = 16'h3456; vecs[4].done = 1; vecs[4].idx = 3; vecs[4].writes = 2;
      vecs[5] = blank();
      for (int k = 0; k < N; k++) vecs[5].tbl[k] = {8'(k * 17 + 1), 8'(k)};
      vecs[5].done = 1; vecs[5].idx = 7; vecs[5].writes = 8;
      vecs[6] = vecs[5]; vecs[6].tbl[7] = 16'hFE00; vecs[6].writes = 7;
      vecs[7] = vecs[0]; vecs[7].mute[0] = 1'b1;
      vecs[7].done = 0; vecs[7].err = 1; vecs[7].eidx = 0; vecs[7].idx = 0; vecs[7].writes = 0;

      load_vec(vecs[0]);
      rst_n = 1'b0; start = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 8; v++) begin
         load_vec(vecs[v]);
         run_pass(v == 1);
         check_rec(v);
         chk($sformatf("v%0d_writes", v), m_n, vecs[v].writes);
         if (v == 0) begin
            chk("first_en_not_early", first_en >= SD + 2, 1);
            chk("first_en_not_late", first_en <= SD + 3, 1);
         end
         if (v == 1) begin
            load_vec(vecs[1]);
            run_pass(0);
            check_rec(1);
         end
         if (v == 4) chk("delay_dwell", (dwell1 >= 2 + 2 * DU) && (dwell1 <= 3 + 2 * DU), 1);
         if (v == 7) chk("busy_timeout_len", maxrun, BT);
      end

      // Reset while the slave is mid-transaction.
      load_vec(vecs[1]);
      fix_len = 20;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!(sccb_busy && !sccb_en) && cyc < BUDGET) begin tick(); cyc++; end
      chk("wait_done_reached", sccb_busy && !sccb_en && running, 1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("rst_wait_done");
      rst_n = 1'b1;
      fix_len = 2;
      tick();

      rnd_len = 1; rnd_ready = 1;
      for (int p = 0; p < 20; p++) begin
         for (int k = 0; k < N; k++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      begin rom_a[k] = 8'hFF; rom_d[k] = 8'hFF; end
            else if (r == 1) begin rom_a[k] = 8'hFE; rom_d[k] = 8'($urandom_range(0, 3)); end
            else if (r == 2) begin rom_a[k] = 8'hFF; rom_d[k] = 8'($urandom_range(0, 254)); end
            else             begin rom_a[k] = 8'($urandom_range(0, 253)); rom_d[k] = 8'($urandom); end
            r = int'($urandom_range(0, 9));
            cfg_nack[k] = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            cfg_mute[k] = ($urandom_range(0, 19) == 0);
         end
         run_pass(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
